// File: rtl/fifo_4xnb_ctrl_pkg.sv
// Shared constants and occupancy decode for the 4-entry FIFO controller.
package fifo_4xnb_ctrl_pkg;

    localparam int DEPTH = 4;
    localparam int LVL_W = 3;
    localparam int PTR_W = 2;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_e;

    function automatic occ_e occ_of(input logic [LVL_W-1:0] cnt);
        occ_e o;
        o = OCC_PARTIAL;
        if (cnt == '0)
            o = OCC_EMPTY;
        else if (cnt == LVL_W'(DEPTH))
            o = OCC_FULL;
        return o;
    endfunction

endpackage

// File: rtl/fifo_4xnb_ctrl_regfile.sv
// 4-entry register file: one synchronous write port, one combinational read port.
module regfile_4xnb_1clk #(
    parameter int AW = 2,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          wen_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2**AW];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wen_i)
            mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fifo_4xnb_ctrl.sv
// 4-deep FIFO controller: pointers, occupancy count and valid/ready handshakes
// around a 4-entry register file.
module fifo_4xnb_ctrl
    import fifo_4xnb_ctrl_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [DW-1:0]    push_data_i,
    output logic             pop_valid_o,
    input  logic             pop_ready_i,
    output logic [DW-1:0]    pop_data_o,
    output logic [LVL_W-1:0] level_o
);

    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [LVL_W-1:0] count_q;
    logic [LVL_W-1:0] count_d;
    logic             push;
    logic             pop;
    occ_e             occ;

    // Handshake outputs depend only on the registered count.
    assign occ          = occ_of(count_q);
    assign push_ready_o = (occ != OCC_FULL);
    assign pop_valid_o  = (occ != OCC_EMPTY);
    assign level_o      = count_q;

    assign push = push_valid_i & push_ready_o;
    assign pop  = pop_valid_o & pop_ready_i;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                wptr_q <= wptr_q + 1'b1;
            if (pop)
                rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    regfile_4xnb_1clk #(
        .AW(AW),
        .DW(DW)
    ) u_mem (
        .clk     (clk),
        .wen_i   (push & ~flush_i),
        .waddr_i (wptr_q),
        .wdata_i (push_data_i),
        .raddr_i (rptr_q),
        .rdata_o (pop_data_o)
    );

    // A stalled producer may withdraw, but must not change data while still offering.
    a_push_data_stable: assert property (
        @(posedge clk) disable iff (rst_i)
        (push_valid_i && !push_ready_o) |=> (!push_valid_i || $stable(push_data_i))
    );

endmodule

// File: tb/tb_fifo_4xnb_ctrl.sv
// Directed self-checking bench for fifo_4xnb_ctrl.
module tb_fifo_4xnb_ctrl;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       flush_i;
    logic       push_valid_i;
    logic       push_ready_o;
    logic [7:0] push_data_i;
    logic       pop_valid_o;
    logic       pop_ready_i;
    logic [7:0] pop_data_o;
    logic [2:0] level_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_4xnb_ctrl #(.DW(8), .AW(2)) dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .push_valid_i (push_valid_i),
        .push_ready_o (push_ready_o),
        .push_data_i  (push_data_i),
        .pop_valid_o  (pop_valid_o),
        .pop_ready_i  (pop_ready_i),
        .pop_data_o   (pop_data_o),
        .level_o      (level_o)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] v);
        push_valid_i = 1'b1;
        push_data_i  = v;
        step();
        push_valid_i = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, {7'd0, pop_valid_o}, 8'd1);
        chk({tag, "_data"}, pop_data_o, exp);
        pop_ready_i = 1'b1;
        step();
        pop_ready_i = 1'b0;
    endtask

    initial begin
        rst_i        = 1'b1;
        flush_i      = 1'b0;
        push_valid_i = 1'b0;
        push_data_i  = 8'h00;
        pop_ready_i  = 1'b0;

        // 1. reset is visible before any clock edge
        #3;
        chk("rst_level", {5'd0, level_o}, 8'd0);
        chk("rst_pop_valid", {7'd0, pop_valid_o}, 8'd0);
        chk("rst_push_ready", {7'd0, push_ready_o}, 8'd1);
        step();
        step();
        rst_i = 1'b0;
        step();

        // 2. fill, overflow attempt, drain
        push_word(8'h11);
        chk("fill1_level", {5'd0, level_o}, 8'd1);
        chk("fill1_head", pop_data_o, 8'h11);
        push_word(8'h22);
        push_word(8'h33);
        push_word(8'h44);
        chk("full_level", {5'd0, level_o}, 8'd4);
        chk("full_push_ready", {7'd0, push_ready_o}, 8'd0);
        push_word(8'h55);
        chk("ovf_level", {5'd0, level_o}, 8'd4);
        pop_check("drain0", 8'h11);
        pop_check("drain1", 8'h22);
        pop_check("drain2", 8'h33);
        pop_check("drain3", 8'h44);
        chk("drained_level", {5'd0, level_o}, 8'd0);
        chk("drained_pop_valid", {7'd0, pop_valid_o}, 8'd0);

        // 3. pointer wrap
        push_word(8'h01);
        push_word(8'h02);
        push_word(8'h03);
        pop_check("pre0", 8'h01);
        pop_check("pre1", 8'h02);
        pop_check("pre2", 8'h03);
        push_word(8'hA0);
        push_word(8'hA1);
        push_word(8'hA2);
        push_word(8'hA3);
        chk("wrap_level", {5'd0, level_o}, 8'd4);
        pop_check("wrap0", 8'hA0);
        pop_check("wrap1", 8'hA1);
        pop_check("wrap2", 8'hA2);
        pop_check("wrap3", 8'hA3);
        chk("wrap_empty", {5'd0, level_o}, 8'd0);

        // 4. simultaneous push and pop at level 2
        push_word(8'hB1);
        push_word(8'hB2);
        chk("sim_head", pop_data_o, 8'hB1);
        push_valid_i = 1'b1;
        push_data_i  = 8'h77;
        pop_ready_i  = 1'b1;
        step();
        push_valid_i = 1'b0;
        pop_ready_i  = 1'b0;
        chk("sim_level", {5'd0, level_o}, 8'd2);
        pop_check("sim0", 8'hB2);
        pop_check("sim1", 8'h77);
        chk("sim_empty", {5'd0, level_o}, 8'd0);

        // 5. full with push and pop offered: only the pop happens
        push_word(8'hC0);
        push_word(8'hC1);
        push_word(8'hC2);
        push_word(8'hC3);
        push_valid_i = 1'b1;
        push_data_i  = 8'hCC;
        pop_ready_i  = 1'b1;
        step();
        push_valid_i = 1'b0;
        pop_ready_i  = 1'b0;
        chk("fp_level", {5'd0, level_o}, 8'd3);
        chk("fp_push_ready", {7'd0, push_ready_o}, 8'd1);
        pop_check("fp0", 8'hC1);
        pop_check("fp1", 8'hC2);
        pop_check("fp2", 8'hC3);
        chk("fp_empty", {5'd0, level_o}, 8'd0);

        // 6. flush at level 3 discards the concurrent push
        push_word(8'hD0);
        push_word(8'hD1);
        push_word(8'hD2);
        chk("pre_flush_level", {5'd0, level_o}, 8'd3);
        flush_i      = 1'b1;
        push_valid_i = 1'b1;
        push_data_i  = 8'hEE;
        pop_ready_i  = 1'b1;
        step();
        flush_i      = 1'b0;
        push_valid_i = 1'b0;
        pop_ready_i  = 1'b0;
        chk("flush_level", {5'd0, level_o}, 8'd0);
        chk("flush_pop_valid", {7'd0, pop_valid_o}, 8'd0);
        push_word(8'hF0);
        chk("post_flush_level", {5'd0, level_o}, 8'd1);
        pop_check("post_flush", 8'hF0);

        // async reset mid-transfer
        push_word(8'h5A);
        push_word(8'h5B);
        #2;
        rst_i = 1'b1;
        #1;
        chk("midrst_level", {5'd0, level_o}, 8'd0);
        chk("midrst_pop_valid", {7'd0, pop_valid_o}, 8'd0);
        step();
        rst_i = 1'b0;
        step();
        push_word(8'h99);
        pop_check("after_rst", 8'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
